// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer and sync_fifo.
// Producer/consumer side is master; the FIFO itself is slave.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  CLEAR;
  logic                  WR_EN;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  RD_EN;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_VALID;
  logic                  FULL;
  logic                  EMPTY;
  logic                  ALMOST_FULL;
  logic                  ALMOST_EMPTY;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output CLEAR, WR_EN, WR_DATA, RD_EN,
    input  RD_DATA, RD_VALID, FULL, EMPTY,
    input  ALMOST_FULL, ALMOST_EMPTY, COUNT,
    input  OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  CLEAR, WR_EN, WR_DATA, RD_EN,
    output RD_DATA, RD_VALID, FULL, EMPTY,
    output ALMOST_FULL, ALMOST_EMPTY, COUNT,
    output OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy
// count, almost thresholds and sticky over/underflow flags.
module sync_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 4
) (
  input logic      CLK,
  input logic      RESET,
  sync_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  if (!(AEMPTY_LEVEL >= 0 &&
        AEMPTY_LEVEL < AFULL_LEVEL &&
        AFULL_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("sync_fifo: need 0 <= AEMPTY < AFULL <= DEPTH");
  end

  word_t mem [DEPTH];
  ptr_t  wptr_q;
  ptr_t  rptr_q;
  cnt_t  count_q;
  cnt_t  count_d;
  word_t rd_data_q;
  logic  rd_valid_q;
  logic  ovf_q;
  logic  unf_q;
  logic  full;
  logic  empty;
  logic  wr_ok;
  logic  rd_ok;

  // Status decodes of the registered count.
  always_comb begin
    full  = (count_q == cnt_t'(DEPTH));
    empty = (count_q == '0);
  end

  // Accept decisions; CLEAR suppresses both requests.
  always_comb begin
    wr_ok = bus.WR_EN & ~full  & ~bus.CLEAR;
    rd_ok = bus.RD_EN & ~empty & ~bus.CLEAR;
  end

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wptr_q] <= bus.WR_DATA;
  end

  // Pointers, count, read register and sticky flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (bus.CLEAR) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_ok;
      if (wr_ok) wptr_q <= wptr_q + ptr_t'(1);
      if (rd_ok) begin
        rd_data_q <= mem[rptr_q];
        rptr_q    <= rptr_q + ptr_t'(1);
      end
      if (bus.WR_EN & full)  ovf_q <= 1'b1;
      if (bus.RD_EN & empty) unf_q <= 1'b1;
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.RD_DATA      = rd_data_q;
    bus.RD_VALID     = rd_valid_q;
    bus.FULL         = full;
    bus.EMPTY        = empty;
    bus.ALMOST_FULL  = (count_q >= cnt_t'(AFULL_LEVEL));
    bus.ALMOST_EMPTY = (count_q <= cnt_t'(AEMPTY_LEVEL));
    bus.COUNT        = count_q;
    bus.OVERFLOW     = ovf_q;
    bus.UNDERFLOW    = unf_q;
  end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parameterised first-in-first-out buffer.
- Registered read data; occupancy count; almost-full and almost-empty thresholds; sticky overflow and underflow error flags.
- General-purpose buffering primitive in the rtl_library, used between producer and consumer logic in the 50 MHz CLK domain.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16)
AFULL_LEVEL, 12, ALMOST_FULL asserts when COUNT >= this value
AEMPTY_LEVEL, 4, ALMOST_EMPTY asserts when COUNT <= this value

Ports:
CLK  input  1  clock; all logic on posedge
RESET  input  1  asynchronous, active-low reset (0 = in reset)
CLEAR  input  1  synchronous flush: empties FIFO, clears error flags
WR_EN  input  1  write request
WR_DATA  input  DATA_WIDTH  write data, sampled on posedge when WR_EN=1
RD_EN  input  1  read request
RD_DATA  output  DATA_WIDTH  registered read data
RD_VALID  output  1  RD_DATA holds a newly popped word (one-cycle pulse)
FULL  output  1  COUNT == DEPTH
EMPTY  output  1  COUNT == 0
ALMOST_FULL  output  1  COUNT >= AFULL_LEVEL
ALMOST_EMPTY  output  1  COUNT <= AEMPTY_LEVEL
COUNT  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
OVERFLOW  output  1  sticky: write attempted while FULL
UNDERFLOW  output  1  sticky: read attempted while EMPTY

Behaviour:
- Reset (RESET=0, asynchronous):
  - Pointers and COUNT go to 0; RD_DATA=0; RD_VALID=0; OVERFLOW=0; UNDERFLOW=0.
  - EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0.
  - Memory contents are not reset.
  - Release is synchronised by the caller; the block takes no action on deassertion beyond resuming normal operation.
- Storage: DEPTH x DATA_WIDTH register array. Write pointer and read pointer are ADDR_WIDTH bits each and wrap naturally from DEPTH-1 to 0.
- Write accepted = WR_EN & ~FULL. On posedge: mem[wptr] <= WR_DATA, then wptr increments.
- Read accepted = RD_EN & ~EMPTY. On posedge: RD_DATA <= mem[rptr], RD_VALID <= 1, then rptr increments.
- Read latency: 1 cycle. Data appears on RD_DATA with RD_VALID=1 in the cycle after RD_EN is sampled. RD_VALID=0 in any cycle following a non-accepted read.
- RD_DATA holds its last value when no read is accepted.
- COUNT update per cycle:
  - write only: +1
  - read only: -1
  - both accepted: unchanged
  - neither: unchanged
- Flags FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are combinational decodes of registered COUNT, so they update in the same cycle COUNT changes.
- Simultaneous WR_EN and RD_EN:
  - When EMPTY: only the write is accepted; the read counts as an underflow. No write-through.
  - When FULL: only the read is accepted; the write counts as an overflow. Write-while-full is not permitted even if a read occurs in the same cycle.
  - Otherwise both are accepted.
- OVERFLOW sets on WR_EN & FULL; UNDERFLOW sets on RD_EN & EMPTY. Both remain set until CLEAR or RESET. A rejected access changes no state other than its flag.
- CLEAR=1 at posedge:
  - Pointers and COUNT go to 0; OVERFLOW and UNDERFLOW go to 0; RD_VALID goes to 0; RD_DATA holds its value.
  - CLEAR has priority over WR_EN and RD_EN in the same cycle; neither request is accepted or flagged.
- Thresholds must satisfy 0 <= AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH. This is checked by an elaboration-time assertion in simulation.
- Reset asserted mid-operation discards all contents immediately.

Test Plan:
- Reset release → EMPTY=1, FULL=0, COUNT=0, RD_VALID=0, OVERFLOW=0, UNDERFLOW=0, RD_DATA=0.
- Write 0x01..0x10 (16 words) → COUNT steps 1..16; ALMOST_FULL asserts when COUNT=12; FULL asserts when COUNT=16. Then read 16 → RD_DATA returns 0x01..0x10 in order, each with RD_VALID one cycle after RD_EN; EMPTY=1 at end.
- FULL, then WR_EN with WR_DATA=0xAA → OVERFLOW=1, COUNT stays 16. A subsequent drain shows no 0xAA. OVERFLOW stays 1 until CLEAR.
- EMPTY, then RD_EN → UNDERFLOW=1, RD_VALID=0, COUNT=0. Same cycle WR_EN with 0x55 → COUNT=1; next read returns 0x55.
- Fill 8 words, then 40 cycles of simultaneous WR_EN/RD_EN with an incrementing pattern → COUNT constant at 8; output sequence is contiguous across pointer wrap; no error flags set.
- Fill 5 words, assert CLEAR together with WR_EN/RD_EN → next cycle COUNT=0, EMPTY=1, flags cleared, RD_VALID=0. Separately, pulse RESET low mid-stream → immediate EMPTY=1, COUNT=0.
